// File: rtl/dds_sine_gen_if.sv
// Tone-control / ROM / sample-path bundle for dds_sine_gen.
// Build option DDS_AMPL_EN adds the 8-bit amplitude input.
interface dds_sine_gen_if #(
    parameter int ACC_W = 24
);
    logic             en;
    logic             load;
    logic [ACC_W-1:0] tuning_word;
    logic [9:0]       phase_ofs;
    logic [7:0]       angle;
    logic [7:0]       sinus_in;
    logic [8:0]       wave_out;
    logic             wave_valid;
    logic             wrap;
`ifdef DDS_AMPL_EN
    logic [7:0]       ampl;

    modport master (
        output en, load, tuning_word, phase_ofs, sinus_in, ampl,
        input  angle, wave_out, wave_valid, wrap
    );
    modport slave (
        input  en, load, tuning_word, phase_ofs, sinus_in, ampl,
        output angle, wave_out, wave_valid, wrap
    );
`else
    modport master (
        output en, load, tuning_word, phase_ofs, sinus_in,
        input  angle, wave_out, wave_valid, wrap
    );
    modport slave (
        input  en, load, tuning_word, phase_ofs, sinus_in,
        output angle, wave_out, wave_valid, wrap
    );
`endif
endinterface

// File: rtl/dds_sine_gen.sv
// DDS phase accumulator, quarter-wave fold and sign restore around an external 1-cycle sine ROM.
// Build option DDS_AMPL_EN adds an amplitude multiply stage (one extra cycle of latency).
module dds_sine_gen #(
    parameter int ACC_W = 24
) (
    input logic           clk,
    input logic           rst,
    dds_sine_gen_if.slave bus
);
`ifdef DDS_AMPL_EN
    localparam int VLD_N = 4;
`else
    localparam int VLD_N = 3;
`endif

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  tw_q, tw_d;
    logic [ACC_W-1:0]  acc_sum;
    logic              carry;
    logic              wrap_q, wrap_d;
    logic [9:0]        phase_idx;
    logic [7:0]        angle_c;
    logic              neg;
    logic              neg_dly_q, neg_dly_d;
    logic [VLD_N-1:0]  vld_q, vld_d;
    logic signed [8:0] sample;
    logic [8:0]        wave_out_q, wave_out_d;
`ifdef DDS_AMPL_EN
    logic signed [8:0]  sample_q, sample_d;
    logic signed [17:0] prod;
`endif

    always_comb begin
        {carry, acc_sum} = {1'b0, acc_q} + {1'b0, tw_q};
        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (bus.en) begin
            acc_d  = acc_sum;
            wrap_d = carry;
        end
        // A simultaneous load only affects steps after this edge.
        tw_d = bus.load ? bus.tuning_word : tw_q;
    end

    // Odd quadrants run the quarter table backwards: 255 - i is ~i.
    always_comb begin
        phase_idx = acc_q[ACC_W-1 -: 10] + bus.phase_ofs;
        neg       = phase_idx[9];
        angle_c   = phase_idx[8] ? ~phase_idx[7:0] : phase_idx[7:0];
    end

    always_comb begin
        neg_dly_d  = neg;
        vld_d      = {vld_q[VLD_N-2:0], bus.en};
        sample     = neg_dly_q ? -$signed({1'b0, bus.sinus_in}) : $signed({1'b0, bus.sinus_in});
        wave_out_d = wave_out_q;
`ifdef DDS_AMPL_EN
        sample_d = vld_q[1] ? sample : sample_q;
        prod     = sample_q * $signed({1'b0, bus.ampl});
        if (vld_q[2]) begin
            wave_out_d = 9'(prod >>> 8);
        end
`else
        if (vld_q[1]) begin
            wave_out_d = sample;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            tw_q       <= '0;
            wrap_q     <= 1'b0;
            neg_dly_q  <= 1'b0;
            vld_q      <= '0;
            wave_out_q <= '0;
`ifdef DDS_AMPL_EN
            sample_q   <= '0;
`endif
        end else begin
            acc_q      <= acc_d;
            tw_q       <= tw_d;
            wrap_q     <= wrap_d;
            neg_dly_q  <= neg_dly_d;
            vld_q      <= vld_d;
            wave_out_q <= wave_out_d;
`ifdef DDS_AMPL_EN
            sample_q   <= sample_d;
`endif
        end
    end

    assign bus.angle      = angle_c;
    assign bus.wave_out   = wave_out_q;
    assign bus.wave_valid = vld_q[VLD_N-1];
    assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_dds_sine_gen.sv
// Directed bench for dds_sine_gen with a registered quarter-wave sine ROM model.
module tb_dds_sine_gen;
    localparam int ACC_W = 24;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [8:0] t2_exp  [4] = '{9'h0FF, 9'h000, 9'h101, 9'h000};
    logic       t5_en   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] t5_ang  [7] = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
    logic       t5_vld  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] t5_wave [7] = '{9'd0, 9'd0, 9'd2, 9'd2, 9'd2, 9'd3, 9'd3};

    always #5 clk = ~clk;

    dds_sine_gen_if #(.ACC_W(ACC_W)) bus ();

    dds_sine_gen #(.ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] rom_val(input logic [7:0] a);
        return 8'($rtoi(255.0 * $sin(3.141592653589793 * real'(a) / 512.0) + 0.5));
    endfunction

    always @(posedge clk) bus.sinus_in <= rom_val(bus.angle);

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.load = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.tuning_word = '0;
        bus.phase_ofs = '0;
`ifdef DDS_AMPL_EN
        bus.ampl = 8'd255;
`endif
        cyc();
        cyc();
        chk("rst_wave", 32'(bus.wave_out), 0);
        chk("rst_valid", 32'(bus.wave_valid), 0);
        chk("rst_wrap", 32'(bus.wrap), 0);
        chk("rst_angle", 32'(bus.angle), 0);
        bus.phase_ofs = 10'h100;
        #1 chk("rst_angle_ofs", 32'(bus.angle), 255);
        bus.phase_ofs = 10'h000;
        rst = 1'b0;

        // Slow ramp: one ROM entry per enabled cycle.
        bus.load = 1'b1;
        bus.tuning_word = 24'h004000;
        cyc();
        bus.load = 1'b0;
        bus.en = 1'b1;
        cyc();
        chk("t1_angle1", 32'(bus.angle), 1);
        chk("t1_valid1", 32'(bus.wave_valid), 0);
        cyc();
        chk("t1_angle2", 32'(bus.angle), 2);
        chk("t1_valid2", 32'(bus.wave_valid), 0);
        cyc();
        chk("t1_angle3", 32'(bus.angle), 3);
        chk("t1_valid3", 32'(bus.wave_valid), 1);
        chk("t1_wave1", 32'(bus.wave_out), 2);
        cyc();
        chk("t1_wave2", 32'(bus.wave_out), 3);
        cyc();
        chk("t1_wave3", 32'(bus.wave_out), 5);

        // Quarter-turn steps: +255, 0, -255, 0 and a wrap every fourth step.
        do_reset();
        bus.load = 1'b1;
        bus.tuning_word = 24'h400000;
        cyc();
        bus.load = 1'b0;
        bus.en = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            cyc();
            chk($sformatf("t2_wrap%0d", n), 32'(bus.wrap), 32'(n % 4 == 0));
            if (n >= 3) begin
                chk($sformatf("t2_wave%0d", n), 32'(bus.wave_out), 32'(t2_exp[(n - 3) % 4]));
                chk($sformatf("t2_valid%0d", n), 32'(bus.wave_valid), 1);
            end
        end
        bus.en = 1'b0;
        cyc();
        chk("t2_wrap_idle", 32'(bus.wrap), 0);

        // Zero increment, phase offset alone selects the quadrant.
        do_reset();
        bus.phase_ofs = 10'h100;
        bus.en = 1'b1;
        cyc();
        chk("t3_angle", 32'(bus.angle), 255);
        cyc();
        cyc();
        chk("t3_wave_pos", 32'(bus.wave_out), 9'h0FF);
        chk("t3_valid", 32'(bus.wave_valid), 1);
        bus.phase_ofs = 10'h300;
        #1 chk("t3_angle_q3", 32'(bus.angle), 255);
        cyc();
        chk("t3_wave_hold", 32'(bus.wave_out), 9'h0FF);
        cyc();
        chk("t3_wave_neg", 32'(bus.wave_out), 9'h101);
        bus.phase_ofs = 10'h3FF;
        #1 chk("t3_angle_3ff", 32'(bus.angle), 0);
        bus.phase_ofs = 10'h2FF;
        #1 chk("t3_angle_2ff", 32'(bus.angle), 255);
        bus.phase_ofs = 10'h000;

        // Load coinciding with en: old increment first, new one after.
        do_reset();
        bus.load = 1'b1;
        bus.tuning_word = 24'h004000;
        cyc();
        bus.en = 1'b1;
        bus.tuning_word = 24'h008000;
        cyc();
        chk("t4_step_old", 32'(bus.angle), 1);
        bus.load = 1'b0;
        cyc();
        chk("t4_step_new1", 32'(bus.angle), 3);
        cyc();
        chk("t4_step_new2", 32'(bus.angle), 5);
        bus.en = 1'b0;

        // Enable gaps: valid follows en two edges later, output held.
        do_reset();
        bus.load = 1'b1;
        bus.tuning_word = 24'h004000;
        cyc();
        bus.load = 1'b0;
        for (int j = 0; j < 7; j++) begin
            bus.en = t5_en[j];
            cyc();
            chk($sformatf("t5_angle%0d", j), 32'(bus.angle), 32'(t5_ang[j]));
            chk($sformatf("t5_valid%0d", j), 32'(bus.wave_valid), 32'(t5_vld[j]));
            chk($sformatf("t5_wave%0d", j), 32'(bus.wave_out), 32'(t5_wave[j]));
        end

        // Reset landing on a carrying, valid-producing edge.
        do_reset();
        bus.load = 1'b1;
        bus.tuning_word = 24'hC00000;
        cyc();
        bus.load = 1'b0;
        bus.en = 1'b1;
        cyc();
        chk("t6_angle1", 32'(bus.angle), 255);
        chk("t6_wrap1", 32'(bus.wrap), 0);
        cyc();
        chk("t6_angle2", 32'(bus.angle), 0);
        chk("t6_wrap2", 32'(bus.wrap), 1);
        rst = 1'b1;
        cyc();
        chk("t6_rst_valid", 32'(bus.wave_valid), 0);
        chk("t6_rst_wave", 32'(bus.wave_out), 0);
        chk("t6_rst_wrap", 32'(bus.wrap), 0);
        chk("t6_rst_angle", 32'(bus.angle), 0);
        rst = 1'b0;
        bus.en = 1'b0;
        cyc();
        chk("t6_gap_valid", 32'(bus.wave_valid), 0);
        bus.en = 1'b1;
        cyc();
        chk("t6_f1_valid", 32'(bus.wave_valid), 0);
        chk("t6_f1_angle", 32'(bus.angle), 0);
        cyc();
        chk("t6_f2_valid", 32'(bus.wave_valid), 0);
        cyc();
        chk("t6_f3_valid", 32'(bus.wave_valid), 1);
        chk("t6_f3_wave", 32'(bus.wave_out), 0);
        bus.en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dds_sine_gen.md
Name: dds_sine_gen

Overview:
- Direct digital synthesis (DDS) front/back end for the quarter-wave sine ROM.
- Runs a phase accumulator and folds the phase into a quarter-wave index that drives the ROM `angle` input.
- Captures the ROM's registered magnitude and applies the quadrant sign to produce a full-wave signed sample stream with a valid strobe.
- Sits between the tone-control registers and the DAC/mixer path.

Parameters:
- ACC_W, 24, phase accumulator and tuning word width (min 10); phase index = acc[ACC_W-1:ACC_W-10].

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  advance accumulator one step this cycle
- load  in  1  capture tuning_word into tw_reg
- tuning_word  in  ACC_W  phase increment per enabled cycle
- phase_ofs  in  10  phase offset added to phase index (mod 1024)
- angle  out  8  quarter-wave index to ROM (combinational from acc/phase_ofs)
- sinus_in  in  8  ROM magnitude, valid 1 cycle after angle
- wave_out  out  9  signed two's-complement sample, range -255..+255
- wave_valid  out  1  wave_out holds a new sample this cycle
- wrap  out  1  one-cycle pulse: accumulator carried out

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: acc=0, tw_reg=0, wave_out=0, wave_valid=0, wrap=0, internal sign/valid pipeline=0. angle follows acc after reset (=fold(phase_ofs)).
- Tuning word:
  - load=1 at edge k → tw_reg=tuning_word after k.
  - load and en at the same edge: the accumulation uses the old tw_reg; the new value applies from the next enabled edge.
- Accumulator:
  - en=1 at edge k → acc <= acc + tw_reg, mod 2^ACC_W.
  - wrap <= carry-out of that add; wrap=0 on any edge with en=0.
  - en=0 → acc holds.
- Folding (combinational on the registered acc):
  - p = acc top 10 bits + phase_ofs, mod 1024.
  - q = p[9:8], i = p[7:0].
  - angle = i for q=0 or 2; angle = 255-i for q=1 or 3.
  - neg = q[1].
- ROM contract: registered, 1-cycle latency; sinus_in(t+1) = |sin| magnitude for angle(t).
- Sign stage: neg is registered once (neg_d) to align with sinus_in. wave_out <= neg_d ? -sinus_in : +sinus_in, sign-extended to 9 bits. -0 yields 0.
- Latency: en=1 at edge k → the corresponding sample appears on wave_out with wave_valid=1 after edge k+2. The valid pipeline is en delayed by 3 registers (k, k+1, k+2).
- Gaps:
  - en low → no new samples. wave_valid is low in the matching cycles.
  - wave_out holds its last value while wave_valid=0.
- Continuous en → one sample per cycle, no bubbles.
- Reset mid-stream: all state cleared at that edge; wave_valid=0 for at least 3 cycles until new en samples propagate. A stale ROM value is never flagged valid.
- phase_ofs changes take effect on angle immediately (combinational); the sample reflects them 2 cycles later regardless of en.

Optional Feature:
- DDS_AMPL_EN defined:
  - Adds port `ampl in 8` (amplitude, 255 ≈ unity).
  - One extra register stage: wave_out <= (signed_sample * ampl) >>> 8, arithmetic shift, 9-bit result.
  - Latency becomes 3 (en at edge k → valid after k+3). The valid pipeline is extended by one.
- Undefined: no ampl port; latency 2 as above.

Test Plan:
- Reset, tw=0x004000 loaded, en continuous, phase_ofs=0 → angle steps 1,2,3...; first wave_valid after 2 cycles with wave_out=+2 (ROM[1]), then +3, +5.
- tw=0x400000, en continuous → wave_out sequence +255, 0, -255 (9'h101), 0 repeating; wrap pulses on every 4th enabled edge.
- tw=0, phase_ofs=0x100, en=1 → angle=255, wave_out constant +255; phase_ofs=0x300 → constant -255 after 2 cycles.
- load with new tw asserted at the same edge as en=1 → that step uses the old increment, the next step uses the new one; check the acc deltas.
- en toggled 1,0,0,1 → wave_valid pattern 1,0,0,1 delayed by 2; acc unchanged during gaps; wave_out held.
- rst pulsed mid-stream for 1 cycle → wave_valid=0 the next cycle; acc=0; wrap=0; wave_out=0; first valid sample 2 cycles after the next en.
